// File: rtl/sram_delay_line.sv
// Long delay line kept in external SRAM: each sample is written at wr_ptr, then the sample DELAY slots back is read out.
// One sample in flight: 5 cycles per sample with a zero-wait bridge (4 while filling); in_ready stays low until the delayed sample is out.
module sram_delay_line #(
  parameter logic [19:0] BASE_WORD   = 20'h00000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          DELAY       = 256,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        err_timeout,
  output logic [20:0] bridge_address,
  output logic [1:0]  bridge_byte_enable,
  output logic        bridge_read,
  output logic        bridge_write,
  output logic [15:0] bridge_write_data,
  input  logic        bridge_acknowledge,
  input  logic [15:0] bridge_read_data
);

  localparam int                    TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2-1:0] DELAY_P = DEPTH_LOG2'(DELAY);
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_READ,
    S_OUT
  } state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] cmd_ptr;
  logic [DEPTH_LOG2-1:0] fill;
  logic [15:0]           sample_q;
  logic [15:0]           out_q;
  logic [TO_W-1:0]       to_cnt;
  logic                  err_q;
  logic                  cmd_active;
  logic                  timed_out;
  logic                  fill_full;
  logic [19:0]           cmd_word;

  assign rd_ptr     = wr_ptr - DELAY_P;
  assign fill_full  = (fill >= DELAY_P);
  assign cmd_active = (state == S_WRITE) || (state == S_READ);
  // Expires on the last permitted command cycle, so the command is held exactly ACK_TIMEOUT cycles.
  assign timed_out  = cmd_active && !bridge_acknowledge && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_WRITE;
      S_WRITE: if (bridge_acknowledge || timed_out) state_nxt = S_GAP;
      S_GAP:   state_nxt = fill_full ? S_READ : S_OUT;
      S_READ:  if (bridge_acknowledge || timed_out) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      sample_q <= '0;
      out_q    <= '0;
      to_cnt   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && in_valid) sample_q <= in_data;
      // Any cycle that does not stay in the same command state restarts the count.
      if (cmd_active && state_nxt == state) to_cnt <= to_cnt + TO_W'(1);
      else                                  to_cnt <= '0;
      if (timed_out) err_q <= 1'b1;
      if (state == S_GAP && !fill_full) out_q <= 16'h0000;
      if (state == S_READ) begin
        if (bridge_acknowledge) out_q <= bridge_read_data;
        else if (timed_out)     out_q <= 16'h0000;
      end
      if (state == S_OUT) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (fill != DELAY_P) fill <= fill + DEPTH_LOG2'(1);
      end
    end
  end

  assign cmd_ptr  = (state == S_READ) ? rd_ptr : wr_ptr;
  assign cmd_word = BASE_WORD + 20'(cmd_ptr);

  assign in_ready           = (state == S_IDLE) && !reset_reset;
  assign out_valid          = (state == S_OUT);
  assign out_data           = out_q;
  assign err_timeout        = err_q;
  assign bridge_write       = (state == S_WRITE);
  assign bridge_read        = (state == S_READ);
  assign bridge_byte_enable = cmd_active ? 2'b11 : 2'b00;
  assign bridge_address     = cmd_active ? {cmd_word, 1'b0} : 21'd0;
  assign bridge_write_data  = (state == S_WRITE) ? sample_q : 16'h0000;

endmodule

// File: tb/tb_sram_delay_line.sv
// Bench for sram_delay_line: behavioural SRAM bridge with configurable wait states and a scoreboard of delayed outputs.
module tb_sram_delay_line;

  localparam logic [19:0] BASE = 20'h00100;
  localparam int          DL2  = 4;
  localparam int          DLY  = 3;
  localparam int          TO   = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        err_timeout;
  logic [20:0] bridge_address;
  logic [1:0]  bridge_byte_enable;
  logic        bridge_read;
  logic        bridge_write;
  logic [15:0] bridge_write_data;
  logic        bridge_acknowledge;
  logic [15:0] bridge_read_data;

  sram_delay_line #(
    .BASE_WORD(BASE), .DEPTH_LOG2(DL2), .DELAY(DLY), .ACK_TIMEOUT(TO)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .err_timeout(err_timeout),
    .bridge_address(bridge_address), .bridge_byte_enable(bridge_byte_enable),
    .bridge_read(bridge_read), .bridge_write(bridge_write),
    .bridge_write_data(bridge_write_data),
    .bridge_acknowledge(bridge_acknowledge), .bridge_read_data(bridge_read_data)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [20:0] waddr;
    logic [15:0] wdata;
    bit          has_rd;
    logic [20:0] raddr;
    int          wlen;
    int          rlen;
  } exp_t;

  exp_t        sb[$];
  int          rd_i = 0;
  logic [15:0] hist[$];
  int          idx = 0;

  function automatic logic [20:0] baddr(input int p);
    logic [19:0] w;
    w = BASE + 20'(p);
    return {w, 1'b0};
  endfunction

  function automatic int widx(input logic [20:0] a);
    logic [19:0] w;
    w = a[20:1] - BASE;
    return 32'(w[3:0]);
  endfunction

  // Bridge model: acknowledges after wait_cycles extra cycles, can withhold a read acknowledge.
  logic [15:0] mem [0:15];
  logic        ack_m = 1'b0;
  logic        ack_stray = 1'b0;
  logic [15:0] rd_m = 16'h0;
  int          wait_cycles = 0;
  int          wcnt = 0;
  bit          mute_rd = 1'b0;

  assign bridge_acknowledge = ack_m | ack_stray;
  assign bridge_read_data   = rd_m;

  always @(posedge clk_clk) begin
    #1;
    ack_m = 1'b0;
    if (bridge_write || bridge_read) begin
      if (bridge_read && mute_rd) begin
        wcnt = 0;
      end else if (wcnt >= wait_cycles) begin
        ack_m = 1'b1;
        wcnt = 0;
        if (bridge_write) mem[widx(bridge_address)] = bridge_write_data;
        else              rd_m = mem[widx(bridge_address)];
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: protocol checks every cycle, transaction record compared against the scoreboard on out_valid.
  bit          w_on = 0, r_on = 0, r_seen = 0, prev_done = 0;
  logic [20:0] w_addr = '0, r_addr = '0;
  logic [15:0] w_dat = '0;
  int          w_len = 0, r_len = 0;

  always @(negedge clk_clk) begin
    exp_t e;
    if (reset_reset) begin
      w_on = 0; r_on = 0; r_seen = 0; prev_done = 0;
      w_len = 0; r_len = 0;
      rd_i = sb.size();
    end else begin
      if (prev_done) check("cmd_drop", 32'(bridge_write | bridge_read), 0);
      if (bridge_write || bridge_read) begin
        check("rw_excl", 32'(bridge_write & bridge_read), 0);
        check("busy_rdy", 32'(in_ready), 0);
        check("be_on", 32'(bridge_byte_enable), 3);
      end else begin
        check("be_off", 32'(bridge_byte_enable), 0);
      end
      if (bridge_write) begin
        if (!w_on) begin
          w_on = 1; w_addr = bridge_address; w_dat = bridge_write_data;
        end else begin
          check("w_addr_hold", 32'(bridge_address), 32'(w_addr));
          check("w_dat_hold", 32'(bridge_write_data), 32'(w_dat));
        end
        w_len++;
      end else begin
        w_on = 0;
      end
      if (bridge_read) begin
        if (!r_on) begin
          r_on = 1; r_seen = 1; r_addr = bridge_address;
        end else begin
          check("r_addr_hold", 32'(bridge_address), 32'(r_addr));
        end
        r_len++;
      end else begin
        r_on = 0;
      end
      prev_done = bridge_acknowledge && (bridge_write || bridge_read);
      if (out_valid) begin
        if (rd_i >= sb.size()) begin
          check("spurious_out", 32'(out_valid), 0);
        end else begin
          e = sb[rd_i];
          rd_i++;
          check("out_data", 32'(out_data), 32'(e.data));
          check("w_addr", 32'(w_addr), 32'(e.waddr));
          check("w_data", 32'(w_dat), 32'(e.wdata));
          check("w_len", w_len, e.wlen);
          check("has_read", 32'(r_seen), 32'(e.has_rd));
          if (e.has_rd) begin
            check("r_addr", 32'(r_addr), 32'(e.raddr));
            check("r_len", r_len, e.rlen);
          end
        end
        r_seen = 0; w_len = 0; r_len = 0;
      end
    end
  end

  task automatic send(input logic [15:0] v);
    exp_t e;
    int   n;
    int   p;
    p       = idx % 16;
    e.waddr = baddr(p);
    e.wdata = v;
    e.wlen  = wait_cycles + 1;
    e.has_rd = (idx >= DLY);
    e.raddr = baddr((p - DLY + 16) % 16);
    e.rlen  = mute_rd ? TO : wait_cycles + 1;
    e.data  = (!e.has_rd || mute_rd) ? 16'h0000 : hist[idx - DLY];
    hist.push_back(v);
    idx++;
    sb.push_back(e);
    @(negedge clk_clk);
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk_clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'(in_ready), 1);
    @(negedge clk_clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rd_i != sb.size() && n < 300) begin
      @(negedge clk_clk);
      n++;
    end
    if (rd_i != sb.size()) check("drain_timeout", rd_i, sb.size());
  endtask

  task automatic do_reset();
    @(negedge clk_clk);
    reset_reset = 1'b1;
    in_valid    = 1'b0;
    hist.delete();
    idx = 0;
    @(posedge clk_clk);
    #1;
    check("rst_write", 32'(bridge_write), 0);
    check("rst_read", 32'(bridge_read), 0);
    check("rst_addr", 32'(bridge_address), 0);
    check("rst_be", 32'(bridge_byte_enable), 0);
    check("rst_wdata", 32'(bridge_write_data), 0);
    check("rst_rdy", 32'(in_ready), 0);
    check("rst_ovld", 32'(out_valid), 0);
    repeat (2) @(posedge clk_clk);
    #1;
    check("rst_odata", 32'(out_data), 0);
    check("rst_err", 32'(err_timeout), 0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    check("rdy_release", 32'(in_ready), 1);
  endtask

  initial begin
    int n;
    do_reset();

    // Fill phase then the first delayed sample.
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    send(16'h4444);
    drain();

    // Pointer wrap-around.
    do_reset();
    for (int i = 0; i < 20; i++) send(16'(i));
    drain();

    // Slow bridge: three wait cycles on every command.
    do_reset();
    wait_cycles = 3;
    for (int i = 0; i < 5; i++) send(16'hA000 + 16'(i));
    drain();
    wait_cycles = 0;

    // Missing read acknowledge; error flag must stick.
    do_reset();
    for (int i = 0; i < 3; i++) send(16'h5000 + 16'(i));
    drain();
    check("err_before", 32'(err_timeout), 0);
    mute_rd = 1'b1;
    send(16'h5003);
    drain();
    mute_rd = 1'b0;
    check("err_set", 32'(err_timeout), 1);
    for (int i = 4; i < 7; i++) send(16'h5000 + 16'(i));
    drain();
    check("err_sticky", 32'(err_timeout), 1);

    // Reset while a write waits for its acknowledge.
    do_reset();
    wait_cycles = 5;
    send(16'hBEEF);
    n = 0;
    while (!bridge_write && n < 20) begin
      @(negedge clk_clk);
      n++;
    end
    check("mid_write_seen", 32'(bridge_write), 1);
    do_reset();
    wait_cycles = 0;
    send(16'h1234);
    drain();

    // Stray acknowledges while idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      ack_stray = 1'b1;
      @(negedge clk_clk);
      ack_stray = 1'b0;
      check("stray_rdy", 32'(in_ready), 1);
      check("stray_cmd", 32'(bridge_write | bridge_read), 0);
      check("stray_ovld", 32'(out_valid), 0);
    end
    send(16'h7777);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
